// File: rtl/uart_rx_fifo.sv
// UART receiver (configurable width/parity, start-glitch rejection) feeding a first-word
// fall-through RX FIFO, with sticky framing/parity/overrun flags.
//
// state   | meaning
// IDLE    | line idle, waiting for a falling edge on rxs
// START   | half-bit wait, then confirm the start bit is still low
// DATA    | sampling DATA_BITS data bits, LSB first
// PAR     | sampling the parity bit
// STOP    | sampling the stop bit; push, discard or flag
// WAIT_HI | framing error seen, waiting for the line to return high
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 16,
    parameter int AW           = $clog2(FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_pin,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    output logic [AW:0]          count,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 err_clr
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HI} state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, rxs_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_bit_q, par_bit_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   overrun_q, overrun_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0]   mem_d [FIFO_DEPTH];

    logic tick, pop, push, par_ok, fe_set, pe_set, ov_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            rxs_q        <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync1_q      <= rx_pin;
            rxs_q        <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // Storage needs no reset: rd_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign tick   = (cnt_q == '0);
    assign pop    = rd_en && (count_q != '0);
    assign par_ok = ((^shift_q) ^ par_bit_q) == (PARITY == 1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = tick ? cnt_q : cnt_q - 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        push      = 1'b0;
        fe_set    = 1'b0;
        pe_set    = 1'b0;
        ov_set    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d   = START;
                    cnt_d     = HALF_LOAD;
                    bit_idx_d = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (rxs_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = FULL_LOAD;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d[bit_idx_q] = rxs_q;
                    cnt_d              = FULL_LOAD;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    par_bit_d = rxs_q;
                    cnt_d     = FULL_LOAD;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    if (!rxs_q) begin
                        fe_set  = 1'b1;
                        state_d = WAIT_HI;
                    end else if ((PARITY != 0) && !par_ok) begin
                        pe_set = 1'b1;
                    end else if ((count_q == DEPTH) && !pop) begin
                        ov_set = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            WAIT_HI: begin
                if (rxs_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        frame_err_d  = fe_set | (frame_err_q & ~err_clr);
        parity_err_d = pe_set | (parity_err_q & ~err_clr);
        overrun_d    = ov_set | (overrun_q & ~err_clr);
    end

    assign rd_valid   = (count_q != '0);
    assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: two receivers (no parity / even parity) share clock, reset and err_clr.
module tb_uart_rx_fifo;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst, err_clr;
    logic       rx0, rx2, rd_en0, rd_en2;
    logic [7:0] rd_data0, rd_data2;
    logic       rd_valid0, rd_valid2;
    logic [2:0] count0, count2;
    logic       fe0, pe0, ov0, fe2, pe2, ov2;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] q0[$];
    logic [7:0] q2[$];
    logic [7:0] e0, e2;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .rx_pin(rx0), .rd_en(rd_en0), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .count(count0), .frame_err(fe0), .parity_err(pe0),
        .overrun(ov0), .err_clr(err_clr));

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .rx_pin(rx2), .rd_en(rd_en2), .rd_data(rd_data2),
        .rd_valid(rd_valid2), .count(count2), .frame_err(fe2), .parity_err(pe2),
        .overrun(ov2), .err_clr(err_clr));

    // Monitor: every accepted pop is checked against the oldest expected character.
    always @(negedge clk) begin
        if (rd_en0 && rd_valid0) begin
            n_cmp++;
            if (q0.size() == 0) begin
                n_bad++;
                $display("FAIL pop0: got %02h, expected no data", rd_data0);
            end else begin
                e0 = q0.pop_front();
                if (rd_data0 !== e0) begin
                    n_bad++;
                    $display("FAIL pop0: got %02h expected %02h", rd_data0, e0);
                end
            end
        end
        if (rd_en2 && rd_valid2) begin
            n_cmp++;
            if (q2.size() == 0) begin
                n_bad++;
                $display("FAIL pop2: got %02h, expected no data", rd_data2);
            end else begin
                e2 = q2.pop_front();
                if (rd_data2 !== e2) begin
                    n_bad++;
                    $display("FAIL pop2: got %02h expected %02h", rd_data2, e2);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic val, input int cycles, input int pop_at);
        for (int c = 0; c < cycles; c++) begin
            if (which == 0) begin
                rx0 = val; rd_en0 = (c == pop_at);
            end else begin
                rx2 = val; rd_en2 = (c == pop_at);
            end
            @(posedge clk); #1;
        end
        if (which == 0) rd_en0 = 1'b0;
        else rd_en2 = 1'b0;
    endtask

    task automatic send(input int which, input logic [7:0] b, input bit use_par,
                        input logic par, input logic stop_val, input int stop_len,
                        input int pop_at);
        drive(which, 1'b0, CPB, -1);
        for (int i = 0; i < 8; i++) drive(which, b[i], CPB, -1);
        if (use_par) drive(which, par, CPB, -1);
        drive(which, stop_val, stop_len, pop_at);
        drive(which, 1'b1, CPB, -1);
    endtask

    task automatic pop(input int which);
        if (which == 0) rd_en0 = 1'b1;
        else rd_en2 = 1'b1;
        @(posedge clk); #1;
        rd_en0 = 1'b0;
        rd_en2 = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; err_clr = 1'b0;
        rx0 = 1'b1; rx2 = 1'b1; rd_en0 = 1'b0; rd_en2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_count", count0, 0);
        check("reset_valid", rd_valid0, 0);
        check("reset_data", rd_data0, 0);
        check("reset_flags", {fe0, pe0, ov0}, 0);
        rst = 1'b0;
        drive(0, 1'b1, 8, -1);

        // two characters, drained in order
        q0.push_back(8'h55); send(0, 8'h55, 0, 1'b0, 1'b1, CPB, -1);
        q0.push_back(8'hA3); send(0, 8'hA3, 0, 1'b0, 1'b1, CPB, -1);
        check("basic_valid", rd_valid0, 1);
        check("basic_count", count0, 2);
        check("basic_head", rd_data0, 8'h55);
        pop(0);
        check("basic_head2", rd_data0, 8'hA3);
        pop(0);
        check("basic_empty_valid", rd_valid0, 0);
        check("basic_empty_count", count0, 0);

        // start-bit glitch
        drive(0, 1'b0, 5, -1);
        drive(0, 1'b1, 3 * CPB, -1);
        check("glitch_count", count0, 0);
        check("glitch_flags", {fe0, pe0, ov0}, 0);

        // even parity: bad then good
        send(2, 8'h07, 1, 1'b0, 1'b1, CPB, -1);
        check("par_bad_flag", pe2, 1);
        check("par_bad_count", count2, 0);
        pulse_clr();
        check("par_clr", pe2, 0);
        q2.push_back(8'h07); send(2, 8'h07, 1, 1'b1, 1'b1, CPB, -1);
        check("par_good_flag", pe2, 0);
        check("par_good_count", count2, 1);
        pop(2);
        check("par_drained", count2, 0);

        // stop bit held low for three bit times, then a good character
        send(0, 8'h5A, 0, 1'b0, 1'b0, 3 * CPB, -1);
        drive(0, 1'b1, 2 * CPB, -1);
        q0.push_back(8'h41); send(0, 8'h41, 0, 1'b0, 1'b1, CPB, -1);
        check("frame_flag", fe0, 1);
        check("frame_count", count0, 1);
        pop(0);
        check("frame_drained", count0, 0);

        // overrun: fifth character dropped
        q0.push_back(8'h11); send(0, 8'h11, 0, 1'b0, 1'b1, CPB, -1);
        q0.push_back(8'h22); send(0, 8'h22, 0, 1'b0, 1'b1, CPB, -1);
        q0.push_back(8'h33); send(0, 8'h33, 0, 1'b0, 1'b1, CPB, -1);
        q0.push_back(8'h44); send(0, 8'h44, 0, 1'b0, 1'b1, CPB, -1);
        send(0, 8'h55, 0, 1'b0, 1'b1, CPB, -1);
        check("ovr_count", count0, 4);
        check("ovr_flag", ov0, 1);
        check("ovr_head", rd_data0, 8'h11);
        pulse_clr();
        check("ovr_clr", {fe0, ov0}, 0);
        repeat (4) pop(0);
        check("ovr_drained", count0, 0);

        // full FIFO with a pop on the stop-sample cycle: push and pop both land
        q0.push_back(8'h61); send(0, 8'h61, 0, 1'b0, 1'b1, CPB, -1);
        q0.push_back(8'h62); send(0, 8'h62, 0, 1'b0, 1'b1, CPB, -1);
        q0.push_back(8'h63); send(0, 8'h63, 0, 1'b0, 1'b1, CPB, -1);
        q0.push_back(8'h64); send(0, 8'h64, 0, 1'b0, 1'b1, CPB, -1);
        q0.push_back(8'h65); send(0, 8'h65, 0, 1'b0, 1'b1, CPB, 10);
        check("popfull_flag", ov0, 0);
        check("popfull_count", count0, 4);
        check("popfull_head", rd_data0, 8'h62);
        send(0, 8'h66, 0, 1'b0, 1'b1, CPB, -1);
        check("popfull_ovr", ov0, 1);

        // reset in the middle of the data bits
        drive(0, 1'b0, CPB, -1);
        drive(0, 1'b0, 3 * CPB, -1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q0.delete();
        q2.delete();
        check("rst_count", count0, 0);
        check("rst_valid", rd_valid0, 0);
        check("rst_data", rd_data0, 0);
        check("rst_flags", {fe0, pe0, ov0}, 0);
        drive(0, 1'b1, 3 * CPB, -1);
        q0.push_back(8'h3C); send(0, 8'h3C, 0, 1'b0, 1'b1, CPB, -1);
        check("after_rst_count", count0, 1);
        pop(0);
        check("after_rst_empty", count0, 0);
        check("after_rst_flags", {fe0, pe0, ov0}, 0);

        check("q0_left", q0.size(), 0);
        check("q2_left", q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
